dpram_port_arbiter: RTL and testbench
=====================================

# dpram_port_arbiter

Round-robin arbiter that shares one port of the feature-map DPRAM between `NUM_REQ` requesters: the input loader, the weight loader and the output write-back. Each requester issues single 128-bit read or write beats through a req/gnt handshake. The arbiter registers the winning beat onto the DPRAM port and routes the synchronous read data back to the requester that issued it, tagged by a valid strobe. It sits between the systolic-array control FSMs and one DPRAM port (A or B); two instances serve both ports.

## Interface
Parameters:
- `NUM_REQ`, 3: number of requesters (2..8).
- `ADDR_WIDTH`, 19: byte address width, matches DPRAM.
- `INOUT_WIDTH`, 128: beat width, matches DPRAM.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req` in `NUM_REQ`: per-requester beat request, held until granted.
- `req_lock` in `NUM_REQ`: requester asks to keep the grant on its next beat (burst).
- `req_we` in `NUM_REQ`: 1 = write beat, 0 = read beat.
- `req_addr` in `NUM_REQ*ADDR_WIDTH`: flattened addresses; requester i occupies slice `[i*ADDR_WIDTH +: ADDR_WIDTH]`.
- `req_wdata` in `NUM_REQ*INOUT_WIDTH`: flattened write data, same slicing rule.
- `gnt` out `NUM_REQ`: one-hot, combinational; beat accepted when `req[i] & gnt[i]`.
- `rvalid` out `NUM_REQ`: one-hot, read data for requester i valid this cycle.
- `rdata` out `INOUT_WIDTH`: read data, shared by all requesters.
- `mem_we` out 1: to DPRAM `we`, registered.
- `mem_addr` out `ADDR_WIDTH`: to DPRAM `addr`, registered.
- `mem_din` out `INOUT_WIDTH`: to DPRAM `din`, registered.
- `mem_dout` in `INOUT_WIDTH`: from DPRAM `dout`.

## Operation
- Arbitration runs every cycle and grants at most one requester.
- Priority order starts at `ptr` and wraps modulo `NUM_REQ`.
- After every accepted beat by requester k, `ptr` becomes (k+1) mod `NUM_REQ`.
- **Lock:**
  - If the beat accepted in the previous cycle had `req_lock[k]=1` and `req[k]` is still high, k is granted again regardless of `ptr`.
  - The lock ends on the first cycle in which `req[k]=0`, or on an accepted beat with `req_lock[k]=0`.
- **Issue stage (registered):**
  - On acceptance, `mem_we`, `mem_addr` and `mem_din` load requester k's `req_we`, `req_addr` and `req_wdata`.
  - With no acceptance, `mem_we` is 0, and `mem_addr`/`mem_din` hold their values. The resulting DPRAM read is harmless and is not reported.
- **Return tracking:**
  - A 2-stage shift register carries {is_read, id}.
  - Stage 1 loads on the issue cycle; stage 2 drives `rvalid[id]` = is_read.
  - `rdata` = `mem_dout` (pass-through, no register).
  - Write beats produce no `rvalid`.
- There is no backpressure on read return: a requester must accept `rvalid` unconditionally.
- Address alignment and bounds are the requester's responsibility. The arbiter passes addresses unmodified.

## Timing
- Reset values: `gnt`=0 while `rst_n` is low, `rvalid`=0, `mem_we`=0, `mem_addr`=0, `mem_din`=0, `ptr`=0, lock cleared, tracking pipe cleared.
- Handshake in cycle T → `mem_*` valid in T+1 → DPRAM samples at the end of T+1 → `rvalid`/`rdata` in T+2.
- Read latency is 2 cycles.
- Throughput is 1 beat/cycle aggregate. Back-to-back grants to different requesters are allowed.
- Simultaneous requests: only the highest-priority requester wins. Losers keep `req` asserted; the arbiter does not store them.
- Read-after-write to the same address from any requester returns new data if the read is granted at least one cycle after the write.
- Reset mid-operation clears in-flight reads: no `rvalid` after reset deasserts until a new read is accepted.
- `gnt[i]` never asserts when `req[i]`=0.

## Configuration
- `DPRAM_ARB_RR_EN` defined: rotating-pointer round-robin as described.
- `DPRAM_ARB_RR_EN` undefined: fixed priority, requester 0 highest. `ptr` logic is removed, and lock behaviour is unchanged.

## Test plan
- **Reset:** hold `rst_n`=0 with all `req` high → `gnt`, `rvalid` and `mem_we` are all 0; release → `gnt`=001 in the first cycle.
- **Single read:** req0 reads addr 0x00010 → `mem_addr`=0x00010 in T+1; `rvalid`=001 with `rdata`=preloaded bytes 0x10..0x1F in T+2.
- **Round-robin:** req=111 held with lock=0 for 6 cycles → `gnt` sequence 001,010,100,001,010,100. With the macro undefined → 001 in every cycle.
- **Lock:** req1 with lock=1 for 4 beats while req0 and req2 are requesting → `gnt`=010 for 4 consecutive cycles, then 100.
- **Write then read:** req2 writes 0xA5…A5 to 0x00100 at T, req0 reads 0x00100 at T+1 → `rvalid`=001 at T+3 with `rdata`=0xA5…A5; no `rvalid` is generated for the write.
- **Reset mid-read:** accept a read at T, assert `rst_n`=0 at T+1 → `rvalid` stays 0 through T+2 and after release.

Source files
------------

// File: rtl/dpram_port_arbiter.sv
// rtl/dpram_port_arbiter.sv - round-robin/fixed-priority arbiter sharing one DPRAM port
// Optional feature macro: DPRAM_ARB_RR_EN (defined = rotating-pointer round-robin,
// undefined = fixed priority with requester 0 highest). Lock behaviour is the same in both.
module dpram_port_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int ADDR_WIDTH  = 19,
  parameter int INOUT_WIDTH = 128
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             req_lock,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*INOUT_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [NUM_REQ-1:0]             rvalid,
  output logic [INOUT_WIDTH-1:0]         rdata,
  output logic                           mem_we,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  output logic [INOUT_WIDTH-1:0]         mem_din,
  input  logic [INOUT_WIDTH-1:0]         mem_dout
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic                   win_vld;
  logic [IDW-1:0]         win_id;
  logic [IDW-1:0]         idx;

  logic                   lock_vld_q, lock_vld_d;
  logic [IDW-1:0]         lock_id_q, lock_id_d;
  logic                   mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic [INOUT_WIDTH-1:0] mem_din_q, mem_din_d;
  logic                   s1_rd_q, s1_rd_d;
  logic [IDW-1:0]         s1_id_q, s1_id_d;
  logic                   s2_rd_q, s2_rd_d;
  logic [IDW-1:0]         s2_id_q, s2_id_d;
`ifdef DPRAM_ARB_RR_EN
  logic [IDW-1:0]         ptr_q, ptr_d;
`endif

  // Pick the winner: a live lock holder first, otherwise the first requester in priority order.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    idx     = '0;
    if (lock_vld_q && req[lock_id_q]) begin
      win_vld = 1'b1;
      win_id  = lock_id_q;
    end else begin
      for (int o = 0; o < NUM_REQ; o++) begin
`ifdef DPRAM_ARB_RR_EN
        idx = IDW'((int'(ptr_q) + o) % NUM_REQ);
`else
        idx = IDW'(o);
`endif
        if (!win_vld && req[idx]) begin
          win_vld = 1'b1;
          win_id  = idx;
        end
      end
    end
    // Nothing may be granted while reset is held, even with requests pending.
    if (!rst_n) begin
      win_vld = 1'b0;
    end
  end

  // One-hot grant; a grant is only ever produced for an asserted request, so it is an acceptance.
  always_comb begin
    gnt = '0;
    if (win_vld) begin
      gnt[win_id] = 1'b1;
    end
  end

  // Next-state for lock, issue registers, return-tracking pipe and priority pointer.
  always_comb begin
    // A lock only survives an accepted beat that itself asked for the lock; any other cycle clears it.
    lock_vld_d = win_vld & req_lock[win_id];
    lock_id_d  = win_id;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    s1_rd_d    = 1'b0;
    s1_id_d    = win_id;
    s2_rd_d    = s1_rd_q;
    s2_id_d    = s1_id_q;
    if (win_vld) begin
      mem_we_d   = req_we[win_id];
      mem_addr_d = req_addr[win_id*ADDR_WIDTH +: ADDR_WIDTH];
      mem_din_d  = req_wdata[win_id*INOUT_WIDTH +: INOUT_WIDTH];
      s1_rd_d    = ~req_we[win_id];
    end
`ifdef DPRAM_ARB_RR_EN
    ptr_d = ptr_q;
    if (win_vld) begin
      ptr_d = (win_id == IDW'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
    end
`endif
  end

  // State registers; reset also drops any reads still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_vld_q <= 1'b0;
      lock_id_q  <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      s1_rd_q    <= 1'b0;
      s1_id_q    <= '0;
      s2_rd_q    <= 1'b0;
      s2_id_q    <= '0;
`ifdef DPRAM_ARB_RR_EN
      ptr_q      <= '0;
`endif
    end else begin
      lock_vld_q <= lock_vld_d;
      lock_id_q  <= lock_id_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      s1_rd_q    <= s1_rd_d;
      s1_id_q    <= s1_id_d;
      s2_rd_q    <= s2_rd_d;
      s2_id_q    <= s2_id_d;
`ifdef DPRAM_ARB_RR_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

  // Read return: stage 2 of the pipe lines up with the DPRAM's synchronous output.
  always_comb begin
    rvalid = '0;
    if (s2_rd_q) begin
      rvalid[s2_id_q] = 1'b1;
    end
  end

  assign rdata    = mem_dout;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// tb/tb_dpram_port_arbiter.sv - directed self-checking bench for dpram_port_arbiter
module tb_dpram_port_arbiter;

  localparam int N  = 3;
  localparam int AW = 19;
  localparam int DW = 128;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req, req_lock, req_we;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_wdata;
  logic [N-1:0]      gnt, rvalid;
  logic [DW-1:0]     rdata;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_din;
  logic [DW-1:0]     mem_dout;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [DW-1:0] ram [64];

  dpram_port_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .INOUT_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_lock(req_lock), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid),
    .rdata(rdata), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // Read-first synchronous DPRAM model, 16-byte beats, byte 0 in bits [7:0]
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr[9:4]] <= mem_din;
    mem_dout <= ram[mem_addr[9:4]];
  end

  task automatic set_beat(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_we[i]             = we;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; req_lock = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 3'b111; req_lock = '0; req_we = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    tests_run++; if (gnt !== 3'b000) begin tests_failed++; $display("FAIL reset_gnt: got %b expected 000", gnt); end
    tests_run++; if (rvalid !== 3'b000) begin tests_failed++; $display("FAIL reset_rvalid: got %b expected 000", rvalid); end
    tests_run++; if (mem_we !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
    tests_run++; if (mem_addr !== 19'h0) begin tests_failed++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
    rst_n = 1'b1;
    #1;
    tests_run++; if (gnt !== 3'b001) begin tests_failed++; $display("FAIL reset_release_gnt: got %b expected 001", gnt); end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    do_reset();
    set_beat(0, 1'b0, 19'h00010, '0);
    req = 3'b001;
    #1;
    tests_run++; if (gnt !== 3'b001) begin tests_failed++; $display("FAIL read_gnt: got %b expected 001", gnt); end
    @(negedge clk);
    req = '0;
    #1;
    tests_run++; if (mem_addr !== 19'h00010) begin tests_failed++; $display("FAIL read_mem_addr: got %h expected 00010", mem_addr); end
    tests_run++; if (mem_we !== 1'b0) begin tests_failed++; $display("FAIL read_mem_we: got %b expected 0", mem_we); end
    tests_run++; if (rvalid !== 3'b000) begin tests_failed++; $display("FAIL read_rvalid_early: got %b expected 000", rvalid); end
    @(negedge clk);
    #1;
    tests_run++; if (rvalid !== 3'b001) begin tests_failed++; $display("FAIL read_rvalid: got %b expected 001", rvalid); end
    tests_run++; if (rdata !== 128'h1F1E1D1C1B1A19181716151413121110) begin tests_failed++; $display("FAIL read_rdata: got %h expected 1f1e..10", rdata); end
    @(negedge clk);
    #1;
    tests_run++; if (rvalid !== 3'b000) begin tests_failed++; $display("FAIL read_rvalid_after: got %b expected 000", rvalid); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_g [6];
    logic [N-1:0] exp_rv;
`ifdef DPRAM_ARB_RR_EN
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`else
    exp_g = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
`endif
    do_reset();
    set_beat(0, 1'b0, 19'h00000, '0);
    set_beat(1, 1'b0, 19'h00020, '0);
    set_beat(2, 1'b0, 19'h00030, '0);
    req = 3'b111; req_lock = '0;
    for (int i = 0; i < 8; i++) begin
      if (i == 6) req = '0;
      #1;
      if (i < 6) begin
        tests_run++; if (gnt !== exp_g[i]) begin tests_failed++; $display("FAIL rr_gnt[%0d]: got %b expected %b", i, gnt, exp_g[i]); end
      end
      exp_rv = (i >= 2) ? exp_g[i-2] : 3'b000;
      tests_run++; if (rvalid !== exp_rv) begin tests_failed++; $display("FAIL rr_rvalid[%0d]: got %b expected %b", i, rvalid, exp_rv); end
      @(negedge clk);
    end
  endtask

  task automatic test_lock();
    logic [N-1:0] exp_last;
`ifdef DPRAM_ARB_RR_EN
    exp_last = 3'b100;
`else
    exp_last = 3'b001;
`endif
    do_reset();
    set_beat(0, 1'b0, 19'h00000, '0);
    set_beat(1, 1'b0, 19'h00040, '0);
    set_beat(2, 1'b0, 19'h00050, '0);
    for (int i = 0; i < 4; i++) begin
      req      = (i == 0) ? 3'b010 : 3'b111;
      req_lock = (i == 3) ? 3'b000 : 3'b010;
      #1;
      tests_run++; if (gnt !== 3'b010) begin tests_failed++; $display("FAIL lock_gnt[%0d]: got %b expected 010", i, gnt); end
      @(negedge clk);
    end
    req = 3'b101; req_lock = '0;
    #1;
    tests_run++; if (gnt !== exp_last) begin tests_failed++; $display("FAIL lock_release_gnt: got %b expected %b", gnt, exp_last); end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_write_then_read();
    do_reset();
    set_beat(2, 1'b1, 19'h00100, {16{8'hA5}});
    req = 3'b100;
    #1;
    tests_run++; if (gnt !== 3'b100) begin tests_failed++; $display("FAIL wr_gnt: got %b expected 100", gnt); end
    @(negedge clk);
    set_beat(0, 1'b0, 19'h00100, '0);
    req = 3'b001;
    #1;
    tests_run++; if (gnt !== 3'b001) begin tests_failed++; $display("FAIL rd_gnt: got %b expected 001", gnt); end
    tests_run++; if (mem_we !== 1'b1) begin tests_failed++; $display("FAIL wr_mem_we: got %b expected 1", mem_we); end
    tests_run++; if (mem_din !== {16{8'hA5}}) begin tests_failed++; $display("FAIL wr_mem_din: got %h expected a5..a5", mem_din); end
    @(negedge clk);
    req = '0;
    #1;
    tests_run++; if (rvalid !== 3'b000) begin tests_failed++; $display("FAIL wr_no_rvalid: got %b expected 000", rvalid); end
    tests_run++; if (mem_we !== 1'b0) begin tests_failed++; $display("FAIL rd_mem_we: got %b expected 0", mem_we); end
    @(negedge clk);
    #1;
    tests_run++; if (rvalid !== 3'b001) begin tests_failed++; $display("FAIL raw_rvalid: got %b expected 001", rvalid); end
    tests_run++; if (rdata !== {16{8'hA5}}) begin tests_failed++; $display("FAIL raw_rdata: got %h expected a5..a5", rdata); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    set_beat(0, 1'b0, 19'h00010, '0);
    req = 3'b001;
    @(negedge clk);
    rst_n = 1'b0; req = '0;
    #1;
    tests_run++; if (rvalid !== 3'b000) begin tests_failed++; $display("FAIL midrst_rvalid_t1: got %b expected 000", rvalid); end
    @(negedge clk);
    #1;
    tests_run++; if (rvalid !== 3'b000) begin tests_failed++; $display("FAIL midrst_rvalid_t2: got %b expected 000", rvalid); end
    tests_run++; if (mem_addr !== 19'h0) begin tests_failed++; $display("FAIL midrst_mem_addr: got %h expected 0", mem_addr); end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      tests_run++; if (rvalid !== 3'b000) begin tests_failed++; $display("FAIL midrst_rvalid_after[%0d]: got %b expected 000", i, rvalid); end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++)
      for (int j = 0; j < 16; j++)
        ram[i][j*8 +: 8] = 8'(i*16 + j);
    rst_n = 1'b0; req = '0; req_lock = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    @(negedge clk);
    test_reset();
    test_single_read();
    test_round_robin();
    test_lock();
    test_write_then_read();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
